execute_divider: RTL
====================

Name: execute_divider

Overview:
- Parametrised multi-cycle integer divide unit for the execute stage.
- Replaces the fixed-delay divide path with a radix-2 restoring iterative divider that supports signed and unsigned operation.
- Returns quotient as destination value and remainder as upper value, plus the standard 4-bit flags.
- Uses a valid/hold flow-control handshake on both sides, matching the pipeline stage protocol.

Parameters:
- WIDTH, 32, operand/result width in bits (>= 4).
- REG_BITS, 5, width of the destination register index.

Ports:
- clock  input  1  stage clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous; abandons any operation in progress.
- in_valid  input  1  operands presented this cycle.
- in_hold  output  1  upstream must hold operands stable.
- is_signed  input  1  1 = two's-complement divide, 0 = unsigned.
- left_value  input  WIDTH  dividend.
- right_value  input  WIDTH  divisor.
- destination_register  input  REG_BITS  passed through to the output.
- out_valid  output  1  result available.
- out_hold  input  1  downstream stall.
- quotient  output  WIDTH  destination value.
- remainder  output  WIDTH  upper value.
- out_destination_register  output  REG_BITS  captured register index.
- flags  output  4  {has_carry, is_negative, has_overflow, is_zero}.

Behaviour:
- Reset (async, reset_n low):
  - State goes to IDLE.
  - out_valid=0; quotient, remainder, flags and out_destination_register all 0.
  - Iteration counter is cleared.
- States and transitions:
  - IDLE: accept when in_valid. Divide-by-zero or signed overflow goes to DONE; otherwise go to BUSY.
  - BUSY: one quotient bit per cycle, MSB first. After the last iteration, go to FIXUP.
  - FIXUP: apply sign correction, compute flags, go to DONE.
  - DONE: out_valid=1. Go to IDLE on any cycle with out_hold=0.
- Capture: operands are captured in IDLE. In signed mode, magnitudes are captured, and the result signs are recorded: quotient sign = sign(left) XOR sign(right); remainder sign = sign(left).
- Latency: with accept at cycle T, out_valid rises at T+WIDTH+2 (WIDTH BUSY cycles plus FIXUP). Special cases: out_valid rises at T+1.
- Special cases:
  - Divide by zero (right_value==0): quotient = all ones, remainder = left_value, has_overflow=1.
  - Signed overflow (left_value = most-negative, right_value = -1, is_signed=1): quotient = left_value, remainder = 0, has_overflow=1.
- Signed rounding: truncation toward zero. The remainder takes the dividend's sign, and |remainder| < |divisor|.
- Flags: has_carry is always 0. is_negative = quotient[WIDTH-1]. is_zero = (quotient==0). has_overflow is 1 only in the special cases.
- Input handshake: in_hold = in_valid && state!=IDLE. Only one operation is in flight; a new operation is accepted only in IDLE, so no back-to-back accept is possible from DONE.
- Output handshake: outputs are registered and stay stable while out_valid && out_hold.
- Flush:
  - Forces IDLE next cycle and clears out_valid.
  - Does not accept in the flush cycle.
  - Flush takes priority over acceptance and completion.
- Reset during BUSY: abandons the operation immediately; no stale out_valid afterwards.

Optional Feature:
- Macro: EXECUTE_DIVIDER_EARLY_OUT_EN.
- When defined:
  - In IDLE, the unit computes n = WIDTH - leading_zero_count(|dividend|), with a minimum of 1.
  - The dividend magnitude is pre-shifted and BUSY lasts n cycles, so latency = n+2.
  - A zero dividend with a nonzero divisor gives quotient=0, remainder=0, latency 3.
- When undefined: BUSY always lasts WIDTH cycles. Results are bit-identical in both builds.

Test Plan (WIDTH=32):
- Unsigned 100/7, accept at cycle 0 -> out_valid at cycle 34, quotient=14, remainder=2, flags=4'b0000. With EXECUTE_DIVIDER_EARLY_OUT_EN, out_valid at cycle 9.
- Signed -7/2 (0xFFFFFFF9 / 2) -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF, is_negative=1, has_overflow=0.
- 5/0 (either mode) -> out_valid at cycle 1, quotient=0xFFFFFFFF, remainder=5, has_overflow=1. Signed 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0, has_overflow=1, is_negative=1.
- Hold and stall: out_hold held high 5 cycles while in_valid=1 with new operands -> result stable, in_hold=1 throughout. The second operation is accepted in the cycle after the first DONE->IDLE transition.
- Flush at cycle 10 of BUSY -> out_valid never asserted for that op, state IDLE at cycle 11. Next 9/3 -> quotient=3, remainder=0, is_zero=0.
- Assert reset_n=0 mid-BUSY -> out_valid=0 and all outputs 0 immediately. After release, unsigned 0/1 -> quotient=0, is_zero=1.

Source files
------------

// File: rtl/execute_divider_if.sv
// execute_divider_if: operand/result handshake bundle between the execute stage and the divider.
interface execute_divider_if #(
    parameter int WIDTH    = 32,
    parameter int REG_BITS = 5
);
    logic                flush;
    logic                in_valid;
    logic                in_hold;
    logic                is_signed;
    logic [WIDTH-1:0]    left_value;
    logic [WIDTH-1:0]    right_value;
    logic [REG_BITS-1:0] destination_register;
    logic                out_valid;
    logic                out_hold;
    logic [WIDTH-1:0]    quotient;
    logic [WIDTH-1:0]    remainder;
    logic [REG_BITS-1:0] out_destination_register;
    logic [3:0]          flags;
    modport master (
        output flush, in_valid, is_signed, left_value, right_value, destination_register, out_hold,
        input  in_hold, out_valid, quotient, remainder, out_destination_register, flags
    );
    modport slave (
        input  flush, in_valid, is_signed, left_value, right_value, destination_register, out_hold,
        output in_hold, out_valid, quotient, remainder, out_destination_register, flags
    );
endinterface

// File: rtl/execute_divider.sv
// execute_divider: radix-2 restoring signed/unsigned divider with valid/hold handshakes.
// Optional EXECUTE_DIVIDER_EARLY_OUT_EN skips the dividend's leading zeros.
module execute_divider #(
    parameter int WIDTH    = 32,
    parameter int REG_BITS = 5
) (
    input logic              clock,
    input logic              reset_n,
    execute_divider_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_FIXUP, S_DONE} state_t;
    state_t              r_state, w_next;
    logic [WIDTH-1:0]    r_dvd, r_dvs, r_rem, r_quo, r_rmd;
    logic [REG_BITS-1:0] r_dest;
    logic [3:0]          r_flags;
    logic [CW-1:0]       r_cnt, w_n;
    logic                r_qneg, r_rneg;
    logic                w_accept, w_lneg, w_rneg, w_dz, w_ovf, w_special, w_qbit;
    logic [WIDTH-1:0]    w_lmag, w_rmag, w_start, w_fq, w_fr;
    logic [WIDTH:0]      w_trial, w_diff;

    assign w_accept  = r_state == S_IDLE && bus.in_valid && !bus.flush;
    assign w_lneg    = bus.is_signed && bus.left_value[WIDTH-1];
    assign w_rneg    = bus.is_signed && bus.right_value[WIDTH-1];
    assign w_lmag    = w_lneg ? -bus.left_value : bus.left_value;
    assign w_rmag    = w_rneg ? -bus.right_value : bus.right_value;
    assign w_dz      = bus.right_value == '0;
    assign w_ovf     = bus.is_signed && bus.left_value == {1'b1, {(WIDTH-1){1'b0}}} && bus.right_value == '1;
    assign w_special = w_dz || w_ovf;
`ifdef EXECUTE_DIVIDER_EARLY_OUT_EN
    // Iteration count is the dividend's significant bit length; the magnitude is left-aligned to match.
    always_comb begin
        w_n = CW'(1);
        for (int i = 0; i < WIDTH; i++)
            if (w_lmag[i]) w_n = CW'(i + 1);
    end
    assign w_start = w_lmag << (WIDTH - int'(w_n));
`else
    assign w_n     = CW'(WIDTH);
    assign w_start = w_lmag;
`endif
    assign w_trial = {r_rem, r_dvd[WIDTH-1]};
    assign w_diff  = w_trial - {1'b0, r_dvs};
    assign w_qbit  = !w_diff[WIDTH];
    assign w_fq    = r_qneg ? -r_dvd : r_dvd;
    assign w_fr    = r_rneg ? -r_rem : r_rem;

    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = w_special ? S_DONE : S_BUSY;
            S_BUSY:  if (r_cnt == CW'(1)) w_next = S_FIXUP;
            S_FIXUP: w_next = S_DONE;
            S_DONE:  if (!bus.out_hold) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (bus.flush) w_next = S_IDLE;
    end

    always_comb begin
        bus.out_valid = r_state == S_DONE;
        bus.in_hold   = bus.in_valid && r_state != S_IDLE;
    end

    assign bus.quotient                 = r_quo;
    assign bus.remainder                = r_rmd;
    assign bus.flags                    = r_flags;
    assign bus.out_destination_register = r_dest;

    // r_dvd shifts the dividend out while quotient bits shift in; it holds the quotient magnitude at FIXUP.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_dvd   <= '0;
            r_dvs   <= '0;
            r_rem   <= '0;
            r_quo   <= '0;
            r_rmd   <= '0;
            r_dest  <= '0;
            r_flags <= '0;
            r_cnt   <= '0;
            r_qneg  <= 1'b0;
            r_rneg  <= 1'b0;
        end else if (w_accept) begin
            r_dest <= bus.destination_register;
            r_qneg <= w_lneg ^ w_rneg;
            r_rneg <= w_lneg;
            r_dvd  <= w_start;
            r_dvs  <= w_rmag;
            r_rem  <= '0;
            r_cnt  <= w_n;
            if (w_special) begin
                r_quo   <= w_dz ? '1 : bus.left_value;
                r_rmd   <= w_dz ? bus.left_value : '0;
                r_flags <= 4'b0110;
            end
        end else if (r_state == S_BUSY && !bus.flush) begin
            r_rem <= w_qbit ? w_diff[WIDTH-1:0] : w_trial[WIDTH-1:0];
            r_dvd <= {r_dvd[WIDTH-2:0], w_qbit};
            r_cnt <= r_cnt - CW'(1);
        end else if (r_state == S_FIXUP && !bus.flush) begin
            r_quo   <= w_fq;
            r_rmd   <= w_fr;
            r_flags <= {1'b0, w_fq[WIDTH-1], 1'b0, w_fq == '0};
        end
    end
endmodule
